// File: rtl/ap_mult_err_sweep.sv
// Exhaustive error sweep for an external approximate multiplier: steps every operand pair,
// compares the returned product against the exact one and accumulates count/sum/max error.
module ap_mult_err_sweep #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DW-1:0]     muld_o,
    output logic [DW-1:0]     mulr_o,
    input  logic [2*DW-1:0]   res_i,
    output logic              busy,
    output logic              done,
    output logic [2*DW:0]     err_cnt,
    output logic [4*DW-1:0]   err_sum,
    output logic [2*DW-1:0]   max_err
);

    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] idx;
    logic [PW-1:0] d;
    logic          v;
    logic [PW-1:0] exact;
    logic [PW-1:0] d_next;

    // The sweep index is the operand register pair, so operands never lag the index.
    assign muld_o = idx[PW-1:DW];
    assign mulr_o = idx[DW-1:0];

    always_comb begin
        exact  = PW'(muld_o) * PW'(mulr_o);
        d_next = (exact >= res_i) ? (exact - res_i) : (res_i - exact);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            d       <= '0;
            v       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
            err_sum <= '0;
            max_err <= '0;
        end else begin
            // Stage 2 accumulates whatever stage 1 captured on the previous edge.
            if (v) begin
                err_sum <= err_sum + {{(4*DW-PW){1'b0}}, d};
                err_cnt <= err_cnt + {{PW{1'b0}}, (d != '0)};
                if (d > max_err) max_err <= d;
            end
            v <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        idx     <= '0;
                        v       <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        err_cnt <= '0;
                        err_sum <= '0;
                        max_err <= '0;
                    end
                end
                RUN: begin
                    v <= 1'b1;
                    d <= d_next;
                    if (idx == {PW{1'b1}}) begin
                        idx   <= '0;
                        state <= DRAIN;
                    end else begin
                        idx <= idx + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_mult_err_sweep.sv
// Directed bench: full DW=8 sweep against a zero product, then DW=4 sweeps for
// exact, zero and exact+1 products, ignored start, mid-run reset and operand order.
module tb_ap_mult_err_sweep;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small instance (DW=4)
    logic        start = 1'b0;
    logic [3:0]  muld, mulr;
    logic [7:0]  res;
    logic        busy, done;
    logic [8:0]  err_cnt;
    logic [15:0] err_sum;
    logic [7:0]  max_err;
    int          mode = 0;

    // Large instance (DW=8)
    logic        start_b = 1'b0;
    logic [7:0]  muld_b, mulr_b;
    logic [15:0] res_b;
    logic        busy_b, done_b;
    logic [16:0] err_cnt_b;
    logic [31:0] err_sum_b;
    logic [15:0] max_err_b;

    int total = 0;
    int bad   = 0;
    int lat, busyc;

    always_comb begin
        res = 8'd0;
        case (mode)
            0: res = 8'(muld * mulr);
            1: res = 8'd0;
            default: res = 8'(8'(muld * mulr) + 8'd1);
        endcase
    end
    assign res_b = 16'd0;

    ap_mult_err_sweep #(.DW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .muld_o(muld), .mulr_o(mulr),
        .res_i(res), .busy(busy), .done(done), .err_cnt(err_cnt),
        .err_sum(err_sum), .max_err(max_err)
    );

    ap_mult_err_sweep #(.DW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .muld_o(muld_b), .mulr_o(mulr_b),
        .res_i(res_b), .busy(busy_b), .done(done_b), .err_cnt(err_cnt_b),
        .err_sum(err_sum_b), .max_err(max_err_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_metrics(input string tag, input int c, input int s, input int m);
        chk({tag, "_cnt"}, err_cnt, c);
        chk({tag, "_sum"}, err_sum, s);
        chk({tag, "_max"}, max_err, m);
    endtask

    // Pulses start on the small instance and follows the sweep edge by edge.
    task automatic sweep(input int poke_at, input int rst_at, output int l, output int bc);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("clr_done", done, 0);
        chk_metrics("clr", 0, 0, 0);
        l = 0; bc = 0;
        while (!done && l < 1000) begin
            if (busy) bc++;
            if (l < 256) chk("order", {muld, mulr}, l);
            if (l == rst_at) begin
                rst_n = 1'b0; #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ops", {muld, mulr}, 0);
                chk_metrics("rst", 0, 0, 0);
                #2; rst_n = 1'b1;
                return;
            end
            start = (l == poke_at);
            @(posedge clk); #1;
            l++;
        end
        start = 1'b0;
        chk("timeout", done, 1);
    endtask

    initial begin
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ops", {muld, mulr}, 0);
        chk_metrics("reset", 0, 0, 0);
        #20 rst_n = 1'b1;

        // Full-width sweep with the product tied to zero
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 70000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b_done", done_b, 1);
        chk("b_latency", lat, 65537);
        chk("b_cnt", err_cnt_b, 65025);
        chk("b_sum", err_sum_b, 1065369600);
        chk("b_max", max_err_b, 65025);

        // Exact loopback
        mode = 0;
        sweep(-1, -1, lat, busyc);
        chk("exact_lat", lat, 257);
        chk("exact_busy", busyc, 257);
        chk_metrics("exact", 0, 0, 0);

        // Product zero, started from DONE of the previous sweep
        mode = 1;
        sweep(-1, -1, lat, busyc);
        chk("zero_lat", lat, 257);
        chk_metrics("zero", 225, 14400, 225);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", done, 1);
        chk_metrics("hold", 225, 14400, 225);

        // Off by one everywhere
        mode = 2;
        sweep(-1, -1, lat, busyc);
        chk("plus1_lat", lat, 257);
        chk("plus1_busy", busyc, 257);
        chk_metrics("plus1", 256, 256, 1);

        // Start pulsed mid-run is ignored
        mode = 0;
        sweep(100, -1, lat, busyc);
        chk("poke_lat", lat, 257);
        chk_metrics("poke", 0, 0, 0);

        // Reset mid-run aborts; block idles until a fresh start
        mode = 1;
        sweep(-1, 150, lat, busyc);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        sweep(-1, -1, lat, busyc);
        chk("rerun_lat", lat, 257);
        chk_metrics("rerun", 225, 14400, 225);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
